// File: rtl/ex_wb_stage_if.sv
// EX->WB bundle: the EX-side instruction fields driven into the stage
// and the registered writeback, flag and branch results it returns.
// master = producer/consumer of the pipeline (EX side), slave = the stage.
interface ex_wb_if #(
  parameter int DW = 32,
  parameter int RW = 6,
  parameter int CW = 16
);
  logic          ex_valid;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_out;
  logic          alu_z;
  logic          alu_n;
  logic [DW-1:0] mem_data;
  logic          mem_to_reg;
  logic          reg_write;
  logic [RW-1:0] rd;
  logic [1:0]    br_type;
  logic [DW-1:0] br_target;

  logic          wb_valid;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          flag_z;
  logic          flag_n;
  logic          br_taken;
  logic [DW-1:0] br_pc;
  logic          flush;
  logic [CW-1:0] retired;

  modport master (
    output ex_valid, alu_op, alu_out, alu_z, alu_n,
    output mem_data, mem_to_reg, reg_write, rd,
    output br_type, br_target,
    input  wb_valid, wb_we, wb_rd, wb_data,
    input  flag_z, flag_n, br_taken, br_pc,
    input  flush, retired
  );

  modport slave (
    input  ex_valid, alu_op, alu_out, alu_z, alu_n,
    input  mem_data, mem_to_reg, reg_write, rd,
    input  br_type, br_target,
    output wb_valid, wb_we, wb_rd, wb_data,
    output flag_z, flag_n, br_taken, br_pc,
    output flush, retired
  );
endinterface

// File: rtl/ex_wb_stage.sv
// EX/WB stage: registers ALU/mem writeback, keeps Z/N flags, resolves
// branches on stored flags, pulses flush. Ports: clk_i, reset_i, stall_i, bus.
module ex_wb_stage #(
  parameter int DW = 32,
  parameter int RW = 6,
  parameter int CW = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic stall_i,
  ex_wb_if.slave bus
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          wb_valid_q, wb_valid_d;
  logic          wb_we_q, wb_we_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_n_q, flag_n_d;
  logic          br_q, br_d;
  logic [DW-1:0] br_pc_q, br_pc_d;
  logic [CW-1:0] ret_q, ret_d;

  logic accept;
  logic hit;

  // The cycle after a taken branch carries a wrong-path bundle.
  assign accept = bus.ex_valid & ~stall_i & ~br_q;

  // Resolution looks only at the flags stored before this edge.
  always_comb begin
    hit = 1'b0;
    unique case (bus.br_type)
      2'b01:   hit = flag_z_q;
      2'b10:   hit = flag_n_q;
      2'b11:   hit = 1'b1;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    br_d       = 1'b0;
    br_pc_d    = br_pc_q;
    ret_d      = ret_q;
    if (accept) begin
      wb_valid_d = 1'b1;
      wb_we_d    = bus.reg_write;
      wb_rd_d    = bus.rd;
      wb_data_d  = bus.mem_to_reg ? bus.mem_data
                                  : bus.alu_out;
      if (bus.alu_op != 3'b000) begin
        flag_z_d = bus.alu_z;
        flag_n_d = bus.alu_n;
      end
      if (hit) begin
        br_d    = 1'b1;
        br_pc_d = bus.br_target;
      end
      ret_d = ret_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      br_q       <= 1'b0;
      br_pc_q    <= '0;
      ret_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
      br_q       <= br_d;
      br_pc_q    <= br_pc_d;
      ret_q      <= ret_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_n   = flag_n_q;
  assign bus.br_taken = br_q;
  assign bus.br_pc    = br_pc_q;
  assign bus.flush    = br_q;
  assign bus.retired  = ret_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Scoreboard bench for ex_wb_stage: directed vectors push expected
// post-edge state; a monitor pops and compares one record per cycle.
module tb_ex_wb_stage;

  logic clk = 1'b0;
  logic reset;
  logic stall;

  always #5 clk = ~clk;

  ex_wb_if #(.DW(32), .RW(6), .CW(16)) bus ();

  ex_wb_stage #(.DW(32), .RW(6), .CW(16)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .stall_i (stall),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        vld;
    logic [2:0]  op;
    logic [31:0] out;
    logic        z;
    logic        n;
    logic [31:0] md;
    logic        m2r;
    logic        rw;
    logic [5:0]  rd;
    logic [1:0]  bt;
    logic [31:0] tgt;
  } in_t;

  typedef struct {
    logic        v;
    logic        we;
    logic        chk;
    logic [5:0]  rd;
    logic [31:0] data;
    logic        z;
    logic        n;
    logic        bt;
    logic [31:0] pc;
    logic [15:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   row    = 0;
  bit   done   = 0;

  function automatic in_t idle();
    in_t i;
    i = '{rst:0, stl:0, vld:0, op:0, out:0, z:0, n:0,
          md:0, m2r:0, rw:0, rd:0, bt:0, tgt:0};
    return i;
  endfunction

  function automatic exp_t ex(logic v, logic we, logic z,
                              logic n, logic bt,
                              logic [31:0] pc,
                              logic [15:0] ret);
    exp_t e;
    e = '{v:v, we:we, chk:0, rd:0, data:0, z:z, n:n,
          bt:bt, pc:pc, ret:ret};
    return e;
  endfunction

  function automatic exp_t exd(exp_t e, logic [5:0] rd,
                               logic [31:0] d);
    exp_t r;
    r = e;
    r.chk = 1'b1;
    r.rd = rd;
    r.data = d;
    return r;
  endfunction

  task automatic drive(input in_t i, input exp_t e);
    @(negedge clk);
    reset          = i.rst;
    stall          = i.stl;
    bus.ex_valid   = i.vld;
    bus.alu_op     = i.op;
    bus.alu_out    = i.out;
    bus.alu_z      = i.z;
    bus.alu_n      = i.n;
    bus.mem_data   = i.md;
    bus.mem_to_reg = i.m2r;
    bus.reg_write  = i.rw;
    bus.rd         = i.rd;
    bus.br_type    = i.bt;
    bus.br_target  = i.tgt;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic cmp(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL row%0d %s: got %h, expected %h",
               row, nm, a, e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp("wb_valid", 32'(bus.wb_valid), 32'(e.v));
        cmp("wb_we", 32'(bus.wb_we), 32'(e.we));
        cmp("flag_z", 32'(bus.flag_z), 32'(e.z));
        cmp("flag_n", 32'(bus.flag_n), 32'(e.n));
        cmp("br_taken", 32'(bus.br_taken), 32'(e.bt));
        cmp("flush", 32'(bus.flush), 32'(e.bt));
        cmp("br_pc", bus.br_pc, e.pc);
        cmp("retired", 32'(bus.retired), 32'(e.ret));
        if (e.chk) begin
          cmp("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
          cmp("wb_data", bus.wb_data, e.data);
        end
        row++;
      end
    end
  end

  initial begin : stim
    in_t i;
    logic [15:0] r;
    reset = 1'b1;
    stall = 1'b0;
    i = idle();

    // reset, two cycles, idle
    i.rst = 1;
    drive(i, exd(ex(0,0,0,0,0,0,0), 0, 0));
    drive(i, exd(ex(0,0,0,0,0,0,0), 0, 0));

    // add -> 11 into r5
    i = idle(); i.vld = 1; i.op = 3'b100; i.out = 11;
    i.rw = 1; i.rd = 5;
    drive(i, exd(ex(1,1,0,0,0,0,1), 5, 11));

    // load: mem data selected, op 000 keeps flags
    i = idle(); i.vld = 1; i.m2r = 1; i.md = 32'hDEADBEEF;
    i.out = 32'h123; i.z = 1; i.n = 1; i.rw = 1; i.rd = 7;
    drive(i, exd(ex(1,1,0,0,0,0,2), 7, 32'hDEADBEEF));

    // sub 6-6 -> zero
    i = idle(); i.vld = 1; i.op = 3'b001; i.z = 1;
    i.rw = 1; i.rd = 3;
    drive(i, exd(ex(1,1,1,0,0,0,3), 3, 0));

    // BRZ taken
    i = idle(); i.vld = 1; i.bt = 2'b01; i.tgt = 32'h40;
    drive(i, ex(1,0,1,0,1,32'h40,4));

    // wrong-path bundle squashed
    i = idle(); i.vld = 1; i.op = 3'b100; i.out = 99;
    i.n = 1; i.rw = 1; i.rd = 9;
    drive(i, ex(0,0,1,0,0,32'h40,4));

    i = idle();
    drive(i, ex(0,0,1,0,0,32'h40,4));

    // BRN not taken (n=0)
    i = idle(); i.vld = 1; i.bt = 2'b10; i.tgt = 32'h80;
    drive(i, ex(1,0,1,0,0,32'h40,5));

    // stalled negate: ignored
    i = idle(); i.stl = 1; i.vld = 1; i.op = 3'b010;
    i.out = 32'hFFFFFFFA; i.n = 1; i.rw = 1; i.rd = 4;
    drive(i, ex(0,0,1,0,0,32'h40,5));

    i = idle(); i.vld = 1; i.bt = 2'b10; i.tgt = 32'h80;
    drive(i, ex(1,0,1,0,0,32'h40,6));

    // negate for real
    i = idle(); i.vld = 1; i.op = 3'b010;
    i.out = 32'hFFFFFFFA; i.n = 1; i.rw = 1; i.rd = 4;
    drive(i, exd(ex(1,1,0,1,0,32'h40,7), 4, 32'hFFFFFFFA));

    i = idle(); i.vld = 1; i.bt = 2'b10; i.tgt = 32'h80;
    drive(i, ex(1,0,0,1,1,32'h80,8));

    i = idle();
    drive(i, ex(0,0,0,1,0,32'h80,8));

    // back-to-back JUMPs: second squashed
    i = idle(); i.vld = 1; i.bt = 2'b11; i.tgt = 32'h100;
    drive(i, ex(1,0,0,1,1,32'h100,9));
    i.tgt = 32'h200;
    drive(i, ex(0,0,0,1,0,32'h100,9));

    // pulse not repeated under stall
    i = idle(); i.vld = 1; i.bt = 2'b11; i.tgt = 32'h300;
    drive(i, ex(1,0,0,1,1,32'h300,10));
    i.stl = 1;
    drive(i, ex(0,0,0,1,0,32'h300,10));
    i = idle();
    drive(i, ex(0,0,0,1,0,32'h300,10));

    // clear z, then same-edge collision
    i = idle(); i.vld = 1; i.op = 3'b100; i.out = 5;
    i.rw = 1; i.rd = 1;
    drive(i, exd(ex(1,1,0,0,0,32'h300,11), 1, 5));

    i = idle(); i.vld = 1; i.op = 3'b001; i.z = 1;
    i.bt = 2'b01; i.tgt = 32'h500;
    drive(i, ex(1,0,1,0,0,32'h300,12));

    i = idle(); i.vld = 1; i.bt = 2'b01; i.tgt = 32'h600;
    drive(i, ex(1,0,1,0,1,32'h600,13));

    i = idle();
    drive(i, ex(0,0,1,0,0,32'h600,13));

    // run retired up to 0xFFFF, then wrap
    i = idle(); i.vld = 1;
    r = 16'd13;
    for (int k = 0; k < 65522; k++) begin
      r = r + 16'd1;
      drive(i, ex(1,0,1,0,0,32'h600,r));
    end
    drive(i, ex(1,0,1,0,0,32'h600,16'h0000));

    // reset wins over a JUMP accept
    i = idle(); i.rst = 1; i.vld = 1; i.bt = 2'b11;
    i.tgt = 32'h700; i.op = 3'b100; i.z = 1; i.rw = 1;
    drive(i, exd(ex(0,0,0,0,0,0,0), 0, 0));
    i = idle();
    drive(i, exd(ex(0,0,0,0,0,0,0), 0, 0));

    @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
